eight_3bin_encoder: RTL and testbench

- Registered 8-to-3 priority encoder for board switch/button inputs: the return path of the team's 3-to-8 LED decoder.
- Synchronises and debounces eight raw asynchronous inputs, then encodes the highest-index active bit into a 3-bit code.
- Produces a valid flag and a one-cycle change pulse for downstream logic (e.g. driving the decoder or a display controller).

---
 rtl/eight_3bin_encoder.sv | 86 ++++++++
 tb/tb_eight_3bin_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eight_3bin_encoder.sv
// eight_3bin_encoder: registered 8-to-3 priority encoder for board switches/buttons.
// Raw inputs are double-flop synchronised, debounced per bit, then the highest
// set debounced bit is encoded into a 3-bit code with a valid flag and a
// one-cycle change pulse whenever {valid,code} moves.
module eight_3bin_encoder #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] sw,
    output logic [2:0] code,
    output logic       valid,
    output logic       chg,
    output logic [7:0] stable_sw
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [CNT_W-1:0] cnt [8];
    logic [2:0]       next_code;
    logic             next_valid;

    // Two-flop synchroniser per bit to tame the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Per-bit debounce: a bit only updates after DB_CYCLES consecutive differing edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_sw <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == stable_sw[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable_sw[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority encode the debounced vector; the highest index wins because later loop passes overwrite.
    always_comb begin
        next_code  = 3'd0;
        next_valid = 1'b0;
        if (en && (stable_sw != 8'h00)) begin
            next_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (stable_sw[i]) begin
                    next_code = 3'(i);
                end
            end
        end
    end

    // Register the encoder result and flag any change of {valid,code} for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code  <= 3'd0;
            valid <= 1'b0;
            chg   <= 1'b0;
        end else begin
            code  <= next_code;
            valid <= next_valid;
            chg   <= ({next_valid, next_code} != {valid, code});
        end
    end

endmodule

// File: tb/tb_eight_3bin_encoder.sv
// tb_eight_3bin_encoder: directed scenarios plus randomized switch activity,
// every cycle compared against a sliding-window reference model of the encoder.
module tb_eight_3bin_encoder;

    localparam int DB = 4;
    localparam int HL = DB + 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] sw;
    logic [2:0] code;
    logic       valid;
    logic       chg;
    logic [7:0] stable_sw;

    int errors;
    int checks;
    int chgCount;

    // Reference model state: newest-first history of sampled sw values.
    logic [7:0] hist [HL];
    logic [7:0] mStable;
    logic [2:0] mCode;
    logic       mValid;
    logic       mChg;

    eight_3bin_encoder #(
        .DB_CYCLES(DB),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sw(sw),
        .code(code),
        .valid(valid),
        .chg(chg),
        .stable_sw(stable_sw)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge. The value debounced at this edge is
    // the sw sampled two edges earlier; a bit flips when the last DB such
    // samples all disagree with the current debounced level.
    task automatic modelStep(input logic r, input logic e, input logic [7:0] s);
        logic [7:0] prev;
        logic [7:0] nxt;
        logic       nv;
        logic [2:0] nc;
        bit         allDiff;
        if (!r) begin
            for (int k = 0; k < HL; k++) hist[k] = 8'h00;
            mStable = 8'h00;
            mCode   = 3'd0;
            mValid  = 1'b0;
            mChg    = 1'b0;
            return;
        end
        prev = mStable;
        for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        nxt = prev;
        for (int b = 0; b < 8; b++) begin
            allDiff = 1'b1;
            for (int k = 2; k < HL; k++) begin
                if (hist[k][b] == prev[b]) allDiff = 1'b0;
            end
            if (allDiff) nxt[b] = ~prev[b];
        end
        nv = e && (prev != 8'h00);
        nc = nv ? 3'($clog2(int'(prev) + 1) - 1) : 3'd0;
        mChg    = ({nv, nc} != {mValid, mCode});
        mValid  = nv;
        mCode   = nc;
        mStable = nxt;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] s);
        @(negedge clk);
        rst_n = r;
        en    = e;
        sw    = s;
        @(posedge clk);
        modelStep(r, e, s);
        #1;
        checkOutput("stable_sw", 32'(stable_sw), 32'(mStable));
        checkOutput("code", 32'(code), 32'(mCode));
        checkOutput("valid", 32'(valid), 32'(mValid));
        checkOutput("chg", 32'(chg), 32'(mChg));
        chgCount += int'(chg);
    endtask

    task automatic holdFor(input int n, input logic e, input logic [7:0] s);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, e, s);
    endtask

    initial begin
        int riseAt;
        logic [7:0] rv;
        logic re;
        int holdLen;
        errors   = 0;
        checks   = 0;
        chgCount = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        sw       = 8'h00;
        for (int k = 0; k < HL; k++) hist[k] = 8'h00;
        mStable = 8'h00;
        mCode   = 3'd0;
        mValid  = 1'b0;
        mChg    = 1'b0;

        $display("[TB] reset and idle");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 8'hFF);
        chgCount = 0;
        holdFor(8, 1'b1, 8'h00);
        checkOutput("idle_chg_count", 32'(chgCount), 0);

        $display("[TB] clean press");
        chgCount = 0;
        holdFor(10, 1'b1, 8'h04);
        checkOutput("press_chg_count", 32'(chgCount), 1);
        checkOutput("press_code", 32'(code), 2);
        checkOutput("press_stable", 32'(stable_sw), 32'h04);

        $display("[TB] priority");
        chgCount = 0;
        holdFor(10, 1'b1, 8'h84);
        checkOutput("prio7_chg_count", 32'(chgCount), 1);
        checkOutput("prio7_code", 32'(code), 7);
        chgCount = 0;
        holdFor(10, 1'b1, 8'h86);
        checkOutput("prio_low_chg_count", 32'(chgCount), 0);
        chgCount = 0;
        holdFor(10, 1'b1, 8'h06);
        checkOutput("prio2_chg_count", 32'(chgCount), 1);
        checkOutput("prio2_code", 32'(code), 2);

        $display("[TB] glitch rejection");
        chgCount = 0;
        for (int g = 0; g < 5; g++) begin
            holdFor(3, 1'b1, 8'h26);
            holdFor(2, 1'b1, 8'h06);
        end
        holdFor(4, 1'b1, 8'h06);
        checkOutput("glitch_chg_count", 32'(chgCount), 0);
        checkOutput("glitch_bit5", 32'(stable_sw[5]), 0);
        holdFor(8, 1'b1, 8'h26);
        checkOutput("accept_bit5", 32'(stable_sw[5]), 1);
        checkOutput("accept_code", 32'(code), 5);

        $display("[TB] enable gating");
        holdFor(12, 1'b1, 8'h10);
        checkOutput("en_code_before", 32'(code), 4);
        chgCount = 0;
        holdFor(4, 1'b0, 8'h10);
        checkOutput("en_off_valid", 32'(valid), 0);
        holdFor(4, 1'b1, 8'h10);
        checkOutput("en_toggle_chg_count", 32'(chgCount), 2);
        checkOutput("en_stable", 32'(stable_sw), 32'h10);

        $display("[TB] reset mid-debounce");
        holdFor(10, 1'b1, 8'h00);
        holdFor(4, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h01);
        riseAt = -1;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b1, 8'h01);
            if (riseAt < 0 && stable_sw[0]) riseAt = k;
        end
        checkOutput("reset_restart_edge", 32'(riseAt), 32'(DB + 2));

        $display("[TB] randomized activity");
        rv = 8'h00;
        re = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: rv = 8'h00;
                1: rv = rv ^ (8'h01 << $urandom_range(0, 7));
                default: rv = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) re = ~re;
            holdLen = $urandom_range(1, 3 * DB);
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b0, re, rv);
            end else begin
                holdFor(holdLen, re, rv);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
